// File: rtl/tmem_stream_loader.sv
// Host word stream to interleaved TMEM write port: small FIFO in front, then
// virtual address split into bank select (low bits) and in-bank address (high bits).
`timescale 1ns/1ps
module tmem_stream_loader #(
    parameter int WB_WIDTH   = 32,
    parameter int BANKS      = 4,
    parameter int BANK_BITS  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                START_I,
    input  logic [WB_WIDTH-1:0] BASE_I,
    input  logic [WB_WIDTH-1:0] COUNT_I,
    input  logic [WB_WIDTH-1:0] DAT_I,
    input  logic                STB_I,
    output logic                ACK_O,
    output logic [WB_WIDTH-1:0] TMDAT_O,
    output logic [WB_WIDTH-1:0] TMADR_O,
    output logic                TMWE_O,
    output logic [BANKS-1:0]    TMSEL_O,
    output logic                BUSY_O,
    output logic                DONE_O
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WB_WIDTH-1:0]  count_q, accepted_q, wr_vadr_q;
    logic [WB_WIDTH-1:0]  accepted_inc;
    logic [WB_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]     wr_ptr_q, rd_ptr_q;
    logic                 fifo_empty, fifo_full, push, pop;
    logic [WB_WIDTH-1:0]  tmdat_q, tmadr_q;
    logic [BANKS-1:0]     tmsel_q;
    logic                 tmwe_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                          (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop          = ~fifo_empty;
    assign accepted_inc = accepted_q + WB_WIDTH'(1);

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign ACK_O = STB_I && (state_q == S_LOAD) && (~fifo_full || pop) &&
                   (accepted_q < count_q);
    assign push  = ACK_O;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START_I) state_d = (COUNT_I != '0) ? S_LOAD : S_DONE;
            S_LOAD:  if (push && (accepted_inc == count_q)) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= DAT_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            accepted_q <= '0;
            wr_vadr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tmdat_q    <= '0;
            tmadr_q    <= '0;
            tmsel_q    <= '0;
            tmwe_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && START_I) begin
                count_q    <= COUNT_I;
                accepted_q <= '0;
                wr_vadr_q  <= BASE_I;
            end
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + (FIFO_AW+1)'(1);
                accepted_q <= accepted_inc;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + (FIFO_AW+1)'(1);
                tmdat_q   <= fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
                tmadr_q   <= wr_vadr_q >> BANK_BITS;
                tmsel_q   <= BANKS'(wr_vadr_q[BANK_BITS-1:0]);
                wr_vadr_q <= wr_vadr_q + WB_WIDTH'(1);
                tmwe_q    <= 1'b1;
            end else begin
                tmwe_q    <= 1'b0;
            end
        end
    end

    assign TMDAT_O = tmdat_q;
    assign TMADR_O = tmadr_q;
    assign TMSEL_O = tmsel_q;
    assign TMWE_O  = tmwe_q;
    assign BUSY_O  = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign DONE_O  = (state_q == S_DONE);

endmodule

// File: tb/tb_tmem_stream_loader.sv
// Randomized bench for tmem_stream_loader: a job-level model predicts every write
// (address split, data order, two-edge latency), the ACK window, BUSY and the DONE pulse.
`timescale 1ns/1ps
module tb_tmem_stream_loader;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_i = '0, count_i = '0, dat_i = '0;
    logic        stb_i = 1'b0;
    logic        ack_o, tmwe_o, busy_o, done_o;
    logic [31:0] tmdat_o, tmadr_o;
    logic [3:0]  tmsel_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
        logic [31:0] vadr;
    } wr_t;
    wr_t exp_q[$];

    tmem_stream_loader dut (
        .CLK_I(clk), .RST_I(rst_i), .START_I(start_i), .BASE_I(base_i),
        .COUNT_I(count_i), .DAT_I(dat_i), .STB_I(stb_i), .ACK_O(ack_o),
        .TMDAT_O(tmdat_o), .TMADR_O(tmadr_o), .TMWE_O(tmwe_o), .TMSEL_O(tmsel_o),
        .BUSY_O(busy_o), .DONE_O(done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_we"},   32'(tmwe_o),  32'd0);
        check_eq({tag, "_done"}, 32'(done_o),  32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o),  32'd0);
        check_eq({tag, "_sel"},  32'(tmsel_o), 32'd0);
        check_eq({tag, "_adr"},  tmadr_o,      32'd0);
        check_eq({tag, "_dat"},  tmdat_o,      32'd0);
        check_eq({tag, "_ack"},  32'(ack_o),   32'd0);
    endtask

    // stb_mode: 0 = always on, 1 = one-on/two-off, 2 = random.
    task automatic run_job(input logic [31:0] base, input logic [31:0] cnt,
                           input int stb_mode, input int rst_at, input bit start_noise);
        int t, nacks, nwr, last_wr_t, done_t, bound;
        bit stop, exp_we, exp_ack;
        wr_t e;
        exp_q.delete();
        t = 0; nacks = 0; nwr = 0; last_wr_t = -10; stop = 0;
        bound = int'(cnt) * 4 + 40;
        while (!stop) begin
            @(posedge clk); #1;
            exp_we = (exp_q.size() > 0) && (exp_q[0].due == t);
            check_eq("tmwe", 32'(tmwe_o), 32'(exp_we));
            if (exp_we) begin
                e = exp_q.pop_front();
                if (tmwe_o) begin
                    check_eq("tmdat", tmdat_o, e.dat);
                    check_eq("tmsel", 32'(tmsel_o), {30'd0, e.vadr[1:0]});
                    check_eq("tmadr", tmadr_o, e.vadr >> 2);
                end
                nwr++;
                last_wr_t = t;
            end
            done_t = (cnt == 0) ? 1 : ((nwr == int'(cnt)) ? last_wr_t + 1 : -1);
            check_eq("done", 32'(done_o), 32'(t == done_t));
            check_eq("busy", 32'(busy_o),
                     32'(cnt != 0 && t >= 1 && (done_t < 0 || t < done_t)));
            if (done_t >= 0 && t == done_t + 1) begin
                stop = 1;
            end else if (t >= bound) begin
                check_eq("timeout", 32'(t), 32'(bound + 1));
                stop = 1;
            end else begin
                start_i = (t == 0) || (start_noise && t >= 1 && nwr < int'(cnt) &&
                                       $urandom_range(0, 1) == 1);
                base_i  = (t == 0) ? base : $urandom;
                count_i = (t == 0) ? cnt : 32'($urandom_range(0, 30));
                case (stb_mode)
                    0:       stb_i = 1'b1;
                    1:       stb_i = (t % 3 == 1);
                    default: stb_i = ($urandom_range(0, 1) == 1);
                endcase
                dat_i = $urandom;
                #1;
                exp_ack = stb_i && cnt != 0 && t >= 1 && nacks < int'(cnt);
                check_eq("ack", 32'(ack_o), 32'(exp_ack));
                if (exp_ack) begin
                    exp_q.push_back('{t + 2, dat_i, base + 32'(nacks)});
                    nacks++;
                end
                if (rst_at != 0 && nacks == rst_at) begin
                    start_i = 1'b0;
                    rst_i   = 1'b1;
                    @(posedge clk); #1;
                    rst_i = 1'b0;
                    check_idle_outputs("rst_mid");
                    for (int k = 0; k < 6; k++) begin
                        @(posedge clk); #1;
                        check_eq("post_rst_we",   32'(tmwe_o), 32'd0);
                        check_eq("post_rst_busy", 32'(busy_o), 32'd0);
                    end
                    stb_i = 1'b0;
                    exp_q.delete();
                    return;
                end
            end
            t++;
        end
        start_i = 1'b0;
        stb_i   = 1'b0;
        check_eq("writes", 32'(nwr), cnt);
        check_eq("acks", 32'(nacks), cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b, c;
        stb_i = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;
        stb_i = 1'b0;

        run_job(32'h0000_0000, 32'd4,  0, 0, 1'b0);
        run_job(32'h0000_0006, 32'd3,  0, 0, 1'b0);
        run_job(32'h0000_0101, 32'd12, 1, 0, 1'b0);
        run_job(32'h0000_0040, 32'd20, 0, 10, 1'b0);
        run_job(32'h0000_0013, 32'd5,  0, 0, 1'b0);
        run_job(32'h0000_0000, 32'd0,  2, 0, 1'b0);
        run_job(32'hFFFF_FFFE, 32'd3,  0, 0, 1'b1);

        for (int j = 0; j < 40; j++) begin
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : $urandom;
            c = 32'($urandom_range(0, 20));
            run_job(b, c, 2, 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
